free_list: RTL

Physical-register free list for the rename stage. It is a circular FIFO of PRF indices. Rename pops a free physical register for each renamed destination, and the retirement register file pushes the stale physical index it displaces on every commit. On a pipeline flush, all speculative allocations return to the list in one cycle by rewinding the head pointer.

---
 rtl/free_list.sv | 72 +++++++
 1 files changed

// File: rtl/free_list.sv
// Physical-register free list: a circular FIFO of PRF indices. Rename pops from the
// head, retirement pushes at the tail, and a flush rewinds head to undo speculation.
module free_list #(
   parameter int PRF_DEPTH = 64,
   parameter int ARF_DEPTH = 32,
   parameter int PRF_IDX   = $clog2(PRF_DEPTH),
   parameter int FL_DEPTH  = PRF_DEPTH - ARF_DEPTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push_valid,
   input  logic [PRF_IDX-1:0]          push_idx,
   input  logic                        pop_req,
   output logic [PRF_IDX-1:0]          pop_idx,
   output logic                        empty,
   input  logic                        flush,
   output logic [$clog2(FL_DEPTH):0]   count
);

   localparam int IDX_W = $clog2(FL_DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [PRF_IDX-1:0] mem [FL_DEPTH];
   logic [PTR_W-1:0]   head, tail;
   logic [PTR_W-1:0]   head_next, tail_next;
   logic               full;
   logic               push_ok;
   logic               pop_ok;

   // Pointers carry a wrap bit above the index so full and empty stay distinguishable.
   assign empty   = (head == tail);
   assign full    = (head[IDX_W-1:0] == tail[IDX_W-1:0]) && (head[IDX_W] != tail[IDX_W]);
   assign count   = tail - head;
   assign pop_idx = mem[head[IDX_W-1:0]];

   assign push_ok = push_valid && !full;
   assign pop_ok  = pop_req && !empty;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      tail_next = tail;
      head_next = head;
      if (push_ok)
         tail_next = tail + PTR_W'(1);
      // Every allocation beyond the committed ones is speculative, so the committed
      // head is always the tail with its wrap bit inverted; flush snaps head there.
      if (flush)
         head_next = {~tail_next[IDX_W], tail_next[IDX_W-1:0]};
      else if (pop_ok)
         head_next = head + PTR_W'(1);
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         head <= '0;
         tail <= {1'b1, {IDX_W{1'b0}}};
         // NOTE: the storage is reset on purpose; the initial contents are the free registers.
         for (int i = 0; i < FL_DEPTH; i++)
            mem[i] <= PRF_IDX'(ARF_DEPTH + i);
      end else begin
         head <= head_next;
         tail <= tail_next;
         if (push_ok)
            mem[tail[IDX_W-1:0]] <= push_idx;
      end
   end

   // Retirement can never free more registers than rename allocated.
   a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push_valid && full));

endmodule
